// File: rtl/instr_fetch_seq.sv
// -----------------------------------------------------------------------------
// instr_fetch_seq
//   Sequential instruction fetch unit. Reads INSTR_BYTES consecutive bytes from
//   a synchronous instruction ROM (one-cycle read latency), assembles them into
//   one wide word (first byte in the MSBs) and offers it to the decoder with a
//   valid/ready handshake. Keeps a program counter, accepts jumps, stops on a
//   HALT opcode and flags (sticky) any fetch that would run past the ROM end.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        pulse: leave IDLE/HALTED and fetch at the current PC
//   jmp_valid    load PC with jmp_addr, aborting any fetch (highest priority)
//   jmp_addr     jump target byte address
//   rom_cs       ROM read enable
//   rom_addr     ROM byte address
//   rom_data     ROM read data, valid the cycle after rom_cs/rom_addr
//   instr        assembled instruction, byte at instr_pc in the MSBs
//   instr_pc     address of the first byte of instr
//   instr_valid  instr/instr_pc valid
//   instr_ready  decoder accepts instr
//   halted       HALT instruction fetched and delivered
//   err          sticky: an instruction would run past the ROM end
// -----------------------------------------------------------------------------
module instr_fetch_seq #(
  parameter int         ADDR_W      = 6,
  parameter int         DATA_W      = 8,
  parameter int         INSTR_BYTES = 3,
  parameter logic [3:0] HALT_OP     = 4'b1111,
  parameter int         RESET_PC    = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          jmp_valid,
  input  logic [ADDR_W-1:0]             jmp_addr,
  output logic                          rom_cs,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [DATA_W-1:0]             rom_data,
  output logic [INSTR_BYTES*DATA_W-1:0] instr,
  output logic [ADDR_W-1:0]             instr_pc,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic                          halted,
  output logic                          err
);

  localparam int INSTR_W = INSTR_BYTES * DATA_W;
  // PC carries one extra bit so "one past the last byte" is representable
  // (e.g. after a HALT in the final slot) and never silently wraps to 0.
  localparam int PC_W    = ADDR_W + 1;
  localparam int SUM_W   = ADDR_W + 2;
  localparam int CNT_W   = $clog2(INSTR_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DRAIN  = 3'd2,
    VALID  = 3'd3,
    HALTED = 3'd4,
    ERROR  = 3'd5
  } state_t;

  // True when a whole instruction starting at pc lies inside the ROM.
  function automatic logic fits(input logic [PC_W-1:0] pc);
    logic [SUM_W-1:0] end_s;
    end_s = SUM_W'(pc) + SUM_W'(INSTR_BYTES);
    return (end_s <= (SUM_W'(1) << ADDR_W));
  endfunction

  state_t               state_r, state_s;
  logic [PC_W-1:0]      pc_r, pc_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [INSTR_W-1:0]   buf_r, buf_s;
  logic                 rom_cs_r, rom_cs_s;
  logic [ADDR_W-1:0]    rom_addr_r, rom_addr_s;
  logic [INSTR_W-1:0]   instr_r, instr_s;
  logic [ADDR_W-1:0]    instr_pc_r, instr_pc_s;
  logic                 instr_valid_r, instr_valid_s;
  logic                 halted_r, halted_s;
  logic                 err_r, err_s;

  logic [PC_W-1:0]      pc_inc_s;
  logic [PC_W-1:0]      jmp_pc_s;
  logic                 is_halt_s;

  assign pc_inc_s  = pc_r + PC_W'(INSTR_BYTES);
  assign jmp_pc_s  = {1'b0, jmp_addr};
  assign is_halt_s = (instr_r[INSTR_W-1 -: 4] == HALT_OP);

  // Next-state and next-value logic for the whole fetch sequencer.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    cnt_s         = cnt_r;
    buf_s         = buf_r;
    rom_cs_s      = 1'b0;
    rom_addr_s    = rom_addr_r;
    instr_s       = instr_r;
    instr_pc_s    = instr_pc_r;
    instr_valid_s = instr_valid_r;
    halted_s      = halted_r;
    err_s         = err_r;

    if (jmp_valid) begin
      // A jump discards any partial or unaccepted instruction; the stale byte
      // still arriving from the ROM lands while cnt is 0 and is not captured.
      pc_s          = jmp_pc_s;
      cnt_s         = {CNT_W{1'b0}};
      buf_s         = {INSTR_W{1'b0}};
      instr_valid_s = 1'b0;
      case (state_r)
        FETCH, DRAIN, VALID: begin
          if (fits(jmp_pc_s)) begin
            state_s    = FETCH;
            rom_cs_s   = 1'b1;
            rom_addr_s = jmp_addr;
          end else begin
            state_s = ERROR;
            err_s   = 1'b1;
          end
        end
        HALTED: begin
          state_s = HALTED;
        end
        IDLE, ERROR: begin
          state_s = IDLE;
          err_s   = 1'b0;
        end
        default: begin
          state_s = IDLE;
          err_s   = 1'b0;
        end
      endcase
    end else begin
      case (state_r)
        IDLE, HALTED: begin
          if (start) begin
            halted_s = 1'b0;
            cnt_s    = {CNT_W{1'b0}};
            if (fits(pc_r)) begin
              state_s    = FETCH;
              rom_cs_s   = 1'b1;
              rom_addr_s = pc_r[ADDR_W-1:0];
            end else begin
              state_s = ERROR;
              err_s   = 1'b1;
            end
          end else begin
            state_s = state_r;
          end
        end
        FETCH: begin
          // Data for the address issued at cnt-1 is on rom_data now.
          if (cnt_r != {CNT_W{1'b0}}) begin
            buf_s = {buf_r[INSTR_W-DATA_W-1:0], rom_data};
          end else begin
            buf_s = buf_r;
          end
          if (cnt_r == CNT_W'(INSTR_BYTES - 1)) begin
            state_s = DRAIN;
          end else begin
            cnt_s      = cnt_r + CNT_W'(1);
            rom_cs_s   = 1'b1;
            rom_addr_s = rom_addr_r + ADDR_W'(1);
          end
        end
        DRAIN: begin
          instr_s       = {buf_r[INSTR_W-DATA_W-1:0], rom_data};
          instr_pc_s    = pc_r[ADDR_W-1:0];
          instr_valid_s = 1'b1;
          state_s       = VALID;
        end
        VALID: begin
          if (instr_ready) begin
            instr_valid_s = 1'b0;
            pc_s          = pc_inc_s;
            cnt_s         = {CNT_W{1'b0}};
            if (is_halt_s) begin
              state_s  = HALTED;
              halted_s = 1'b1;
            end else if (fits(pc_inc_s)) begin
              state_s    = FETCH;
              rom_cs_s   = 1'b1;
              rom_addr_s = pc_inc_s[ADDR_W-1:0];
            end else begin
              state_s = ERROR;
              err_s   = 1'b1;
            end
          end else begin
            state_s = VALID;
          end
        end
        ERROR: begin
          state_s = ERROR;
          err_s   = 1'b1;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered output state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= PC_W'(RESET_PC);
      cnt_r         <= {CNT_W{1'b0}};
      buf_r         <= {INSTR_W{1'b0}};
      rom_cs_r      <= 1'b0;
      rom_addr_r    <= {ADDR_W{1'b0}};
      instr_r       <= {INSTR_W{1'b0}};
      instr_pc_r    <= {ADDR_W{1'b0}};
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      pc_r          <= pc_s;
      cnt_r         <= cnt_s;
      buf_r         <= buf_s;
      rom_cs_r      <= rom_cs_s;
      rom_addr_r    <= rom_addr_s;
      instr_r       <= instr_s;
      instr_pc_r    <= instr_pc_s;
      instr_valid_r <= instr_valid_s;
      halted_r      <= halted_s;
      err_r         <= err_s;
    end
  end

  assign rom_cs      = rom_cs_r;
  assign rom_addr    = rom_addr_r;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = instr_valid_r;
  assign halted      = halted_r;
  assign err         = err_r;

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Sequential instruction fetch unit. Reads variable-position, fixed-length instructions byte-by-byte from an external synchronous instruction ROM.
- Assembles each instruction into a single wide word and hands it to the decoder with a valid/ready handshake.
- Replaces direct combinational addressing of the instruction ROM. Adds a program counter, jump load, HALT detection and out-of-range error.

Parameters:
- ADDR_W, 6, ROM address width; ROM depth is 1<<ADDR_W bytes.
- DATA_W, 8, ROM byte width.
- INSTR_BYTES, 3, bytes per instruction. Byte 0 is {opcode[7:4], mode_a[3:2], mode_b[1:0]}.
- HALT_OP, 4'b1111, opcode value that stops fetching.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse; leave IDLE/HALTED and begin fetching at current PC
- jmp_valid  input  1  load PC with jmp_addr
- jmp_addr  input  ADDR_W  jump target byte address
- rom_cs  output  1  ROM chip select/read enable
- rom_addr  output  ADDR_W  ROM byte address
- rom_data  input  DATA_W  ROM read data; valid the cycle after rom_cs=1 with rom_addr
- instr  output  INSTR_BYTES*DATA_W  assembled instruction; byte 0 in the MSBs
- instr_pc  output  ADDR_W  address of byte 0 of instr
- instr_valid  output  1  instr/instr_pc valid
- instr_ready  input  1  decoder accepts instr
- halted  output  1  HALT opcode fetched and delivered
- err  output  1  sticky; instruction would run past ROM end

Behaviour:
- Reset (rst_n=0, async):
  - State IDLE, PC=RESET_PC.
  - All outputs 0: rom_cs, rom_addr, instr, instr_pc, instr_valid, halted, err.
- States: IDLE, FETCH, DRAIN, VALID, HALTED, ERROR.
- IDLE:
  - rom_cs=0.
  - start=1 moves to FETCH next cycle.
  - Before entering FETCH, if PC+INSTR_BYTES > 1<<ADDR_W: go to ERROR and set err.
- FETCH:
  - Issue addresses PC, PC+1, ... on consecutive cycles with rom_cs=1; issue counter runs 0..INSTR_BYTES-1.
  - Each rom_data is captured one cycle after its address.
  - After the last address, move to DRAIN for one cycle to capture the final byte.
  - Total: instr_valid rises INSTR_BYTES+1 cycles after FETCH entry. With default 3: address cycles 0-2, last capture at cycle 3, instr_valid=1 in cycle 4.
- VALID:
  - instr_valid=1. instr and instr_pc are held stable until instr_ready=1 while instr_valid=1.
  - On handshake: PC += INSTR_BYTES (no wrap; use the range check above).
  - If opcode==HALT_OP: go to HALTED and set halted.
  - Otherwise go to FETCH directly with no idle cycle; the range check applies, and failing it goes to ERROR.
  - instr_valid drops the cycle after the handshake.
- HALTED:
  - rom_cs=0, halted=1.
  - start clears halted and resumes at PC, the byte after the HALT instruction.
- ERROR:
  - rom_cs=0, err=1.
  - Left only by reset or by jmp_valid.
  - On jmp_valid: clear err, load PC, go to IDLE.
- jmp_valid (any state except reset), priority over everything else:
  - PC <- jmp_addr next cycle.
  - In-progress fetch is aborted; captured bytes are discarded and the late rom_data is ignored.
  - instr_valid is forced 0 next cycle, even if unaccepted.
  - Next state is FETCH if the state was FETCH/DRAIN/VALID; IDLE if IDLE/ERROR; HALTED stays HALTED with the PC updated.
  - jmp_valid together with an instr_ready handshake in the same cycle: the handshake is void (instruction dropped) and the jump wins.
- start while FETCH/DRAIN/VALID: ignored.
- Byte assembly: instr[INSTR_BYTES*DATA_W-1 -: DATA_W] = byte at instr_pc; subsequent bytes fill toward the LSB.
- Async reset mid-fetch returns immediately to the reset values; no partial instruction is ever presented.

Test Plan:
- ROM loaded with 0x10,0x00,0x01 / 0x20,0x08,0x03; pulse start with instr_ready=1 -> rom_addr 0,1,2 with rom_cs=1; instr=0x100001, instr_pc=0, instr_valid in cycle 4; then instr=0x200803, instr_pc=3.
- instr_ready=0 for 5 cycles after valid -> instr stable, rom_cs=0 during the stall; after ready=1, the next fetch starts at addr 3 the following cycle.
- Byte 6 = 0xF0 (HALT) -> after the handshake of instr_pc=6, halted=1, rom_cs=0; start -> fetch resumes at addr 9, halted=0.
- jmp_valid with jmp_addr=0x15 during the second byte of a fetch at PC=0 -> no instr_valid for PC 0; next instr_pc=0x15 with bytes 0x15..0x17.
- jmp_addr=62, start -> 62+3>64, err=1, rom_cs never asserted; jmp_valid with jmp_addr=0 -> err=0, IDLE.
- rst_n low for 1 cycle mid-FETCH -> all outputs 0 asynchronously; start -> fetch restarts at RESET_PC.
